// File: rtl/dut_cfg_chain_emulator.sv
// Loopback emulator of the pixel chip configuration shift chain, with pins oversampled on fw_clk.
// Loads copy the chain into one of two shadow registers. Frame length is checked on every load.
module dut_cfg_chain_emulator #(
  parameter int CFG_WIDTH   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 fw_clk,
  input  logic                 fw_rst_n,
  input  logic                 fw_reset_not,
  input  logic                 fw_config_clk,
  input  logic                 fw_config_in,
  input  logic                 fw_config_load,
  input  logic                 fw_super_pixel_sel,
  output logic                 fw_config_out,
  output logic [CFG_WIDTH-1:0] cfg_shadow0,
  output logic [CFG_WIDTH-1:0] cfg_shadow1,
  output logic [15:0]          cfg_bit_count,
  output logic [7:0]           cfg_load_count,
  output logic                 cfg_load_valid,
  output logic                 cfg_len_err
);

  localparam int P_RST  = 0;
  localparam int P_CLK  = 1;
  localparam int P_IN   = 2;
  localparam int P_LOAD = 3;
  localparam int P_SEL  = 4;

  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic [1:0]                  hist_q, hist_d;
  logic [CFG_WIDTH-1:0]        shift_q, shift_d;
  logic [CFG_WIDTH-1:0]        shadow0_q, shadow0_d;
  logic [CFG_WIDTH-1:0]        shadow1_q, shadow1_d;
  logic [15:0]                 bit_cnt_q, bit_cnt_d;
  logic [7:0]                  load_cnt_q, load_cnt_d;
  logic                        valid_q, valid_d;
  logic                        len_err_q, len_err_d;

  logic [4:0] pin_vec;
  logic [4:0] pin_s;
  logic       clk_rise, load_rise;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pin_vec   = {fw_super_pixel_sel, fw_config_load, fw_config_in, fw_config_clk, fw_reset_not};
  assign pin_s     = sync_q[SYNC_STAGES-1];
  // History tracks the synced value every cycle, including reset, so release produces no phantom edge.
  assign clk_rise  = pin_s[P_CLK]  & ~hist_q[0];
  assign load_rise = pin_s[P_LOAD] & ~hist_q[1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pin_vec};
    hist_d     = {pin_s[P_LOAD], pin_s[P_CLK]};
    shift_d    = shift_q;
    shadow0_d  = shadow0_q;
    shadow1_d  = shadow1_q;
    bit_cnt_d  = bit_cnt_q;
    load_cnt_d = load_cnt_q;
    valid_d    = 1'b0;
    len_err_d  = len_err_q;
    if (!pin_s[P_RST]) begin
      shift_d    = '0;
      shadow0_d  = '0;
      shadow1_d  = '0;
      bit_cnt_d  = '0;
      load_cnt_d = '0;
      len_err_d  = 1'b0;
    end else begin
      if (clk_rise) begin
        shift_d   = {shift_q[CFG_WIDTH-2:0], pin_s[P_IN]};
        bit_cnt_d = sat_inc(bit_cnt_q);
      end
      // A coincident load sees the post-shift chain and count.
      if (load_rise) begin
        if (bit_cnt_d == 16'(CFG_WIDTH)) begin
          if (pin_s[P_SEL]) shadow1_d = shift_d;
          else              shadow0_d = shift_d;
          load_cnt_d = load_cnt_q + 8'd1;
          valid_d    = 1'b1;
        end else begin
          len_err_d = 1'b1;
        end
        bit_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      sync_q     <= '0;
      hist_q     <= '0;
      shift_q    <= '0;
      shadow0_q  <= '0;
      shadow1_q  <= '0;
      bit_cnt_q  <= '0;
      load_cnt_q <= '0;
      valid_q    <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      shift_q    <= shift_d;
      shadow0_q  <= shadow0_d;
      shadow1_q  <= shadow1_d;
      bit_cnt_q  <= bit_cnt_d;
      load_cnt_q <= load_cnt_d;
      valid_q    <= valid_d;
      len_err_q  <= len_err_d;
    end
  end

  assign fw_config_out  = shift_q[CFG_WIDTH-1];
  assign cfg_shadow0    = shadow0_q;
  assign cfg_shadow1    = shadow1_q;
  assign cfg_bit_count  = bit_cnt_q;
  assign cfg_load_count = load_cnt_q;
  assign cfg_load_valid = valid_q;
  assign cfg_len_err    = len_err_q;

endmodule

// File: tb/tb_dut_cfg_chain_emulator.sv
// Randomized bench for dut_cfg_chain_emulator against a transaction-level model of the chain.
`timescale 1ns/1ps
module tb_dut_cfg_chain_emulator;

  localparam int W = 16;

  logic         fw_clk = 1'b0;
  logic         fw_rst_n;
  logic         fw_reset_not;
  logic         fw_config_clk;
  logic         fw_config_in;
  logic         fw_config_load;
  logic         fw_super_pixel_sel;
  logic         fw_config_out;
  logic [W-1:0] cfg_shadow0;
  logic [W-1:0] cfg_shadow1;
  logic [15:0]  cfg_bit_count;
  logic [7:0]   cfg_load_count;
  logic         cfg_load_valid;
  logic         cfg_len_err;

  dut_cfg_chain_emulator #(.CFG_WIDTH(W), .SYNC_STAGES(2)) dut (
    .fw_clk(fw_clk), .fw_rst_n(fw_rst_n), .fw_reset_not(fw_reset_not),
    .fw_config_clk(fw_config_clk), .fw_config_in(fw_config_in),
    .fw_config_load(fw_config_load), .fw_super_pixel_sel(fw_super_pixel_sel),
    .fw_config_out(fw_config_out), .cfg_shadow0(cfg_shadow0), .cfg_shadow1(cfg_shadow1),
    .cfg_bit_count(cfg_bit_count), .cfg_load_count(cfg_load_count),
    .cfg_load_valid(cfg_load_valid), .cfg_len_err(cfg_len_err)
  );

  always #5 fw_clk = ~fw_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int vld_seen = 0;

  // Reference model: the chain as a word, shadows, counters and flags.
  logic [W-1:0] m_chain, m_sh0, m_sh1;
  int           m_bits, m_loads, m_vld;
  logic         m_err, m_rstn;

  always @(posedge fw_clk) if (cfg_load_valid === 1'b1) vld_seen++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_chain = '0; m_sh0 = '0; m_sh1 = '0;
    m_bits = 0; m_loads = 0; m_err = 1'b0;
  endtask

  task automatic model_shift(input logic b);
    if (m_rstn) begin
      m_chain = {m_chain[W-2:0], b};
      if (m_bits < 65535) m_bits++;
    end
  endtask

  task automatic model_load(input logic sel);
    if (m_rstn) begin
      if (m_bits == W) begin
        if (sel) m_sh1 = m_chain;
        else     m_sh0 = m_chain;
        m_loads = (m_loads + 1) % 256;
        m_vld++;
      end else begin
        m_err = 1'b1;
      end
      m_bits = 0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge fw_clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out"},   32'(fw_config_out),  32'(m_chain[W-1]));
    check({tag, "_sh0"},   32'(cfg_shadow0),    32'(m_sh0));
    check({tag, "_sh1"},   32'(cfg_shadow1),    32'(m_sh1));
    check({tag, "_bits"},  32'(cfg_bit_count),  32'(m_bits));
    check({tag, "_loads"}, 32'(cfg_load_count), 32'(m_loads));
    check({tag, "_err"},   32'(cfg_len_err),    32'(m_err));
    check({tag, "_vld"},   32'(vld_seen),       32'(m_vld));
  endtask

  // One config_clk period; out must change exactly 3 fw_clk after the pin rises.
  task automatic shift_bit(input logic b);
    logic old_msb;
    old_msb = m_chain[W-1];
    fw_config_in = b;
    cyc(1);
    fw_config_clk = 1'b1;
    model_shift(b);
    cyc(2);
    check("lat_pre", 32'(fw_config_out), 32'(old_msb));
    cyc(1);
    check("lat_post", 32'(fw_config_out), 32'(m_chain[W-1]));
    cyc(1);
    fw_config_clk = 1'b0;
    cyc(4);
  endtask

  task automatic shift_word(input logic [W-1:0] v, input int nbits);
    for (int i = W - 1; i >= W - nbits; i--) shift_bit(v[i]);
  endtask

  task automatic do_load(input logic sel);
    fw_super_pixel_sel = sel;
    cyc(4);
    fw_config_load = 1'b1;
    model_load(sel);
    cyc(4);
    fw_config_load = 1'b0;
    cyc(4);
  endtask

  task automatic pulse_reset_not();
    fw_reset_not = 1'b0;
    m_rstn = 1'b0;
    model_clear();
    cyc(6);
    fw_reset_not = 1'b1;
    m_rstn = 1'b1;
    cyc(4);
  endtask

  logic [W-1:0] rb;
  logic [W-1:0] rnd;
  logic         rsel;
  int           len;

  initial begin
    fw_rst_n = 1'b0; fw_reset_not = 1'b1; fw_config_clk = 1'b0; fw_config_in = 1'b0;
    fw_config_load = 1'b0; fw_super_pixel_sel = 1'b0;
    m_rstn = 1'b1; m_vld = 0; model_clear();

    // Reset and release
    cyc(3);
    check_all("rst");
    fw_rst_n = 1'b1;
    cyc(6);
    check_all("rel");

    // Shift A5C3 and load to shadow0
    shift_word(16'hA5C3, 16);
    check("pre_load_bits", 32'(cfg_bit_count), 32'd16);
    do_load(1'b0);
    check("a5c3_sh0", 32'(cfg_shadow0), 32'h0000A5C3);
    check("a5c3_loads", 32'(cfg_load_count), 32'd1);
    check_all("load0");

    // Readback: out before each zero shift walks the A5C3 bits
    for (int i = W - 1; i >= 0; i--) begin
      rb[i] = fw_config_out;
      shift_bit(1'b0);
    end
    check("readback", 32'(rb), 32'h0000A5C3);
    check_all("rdbk");

    // Short frame gives a length error
    pulse_reset_not();
    shift_word(16'($urandom), 15);
    do_load(1'b1);
    check("lenerr_flag", 32'(cfg_len_err), 32'd1);
    check_all("lenerr");

    // Last shift and load edges land in the same fw_clk cycle
    pulse_reset_not();
    shift_word(16'h8001, 15);
    fw_super_pixel_sel = 1'b1;
    fw_config_in = 1'b1;
    cyc(4);
    fw_config_clk = 1'b1;
    fw_config_load = 1'b1;
    model_shift(1'b1);
    model_load(1'b1);
    cyc(4);
    fw_config_clk = 1'b0;
    fw_config_load = 1'b0;
    cyc(4);
    check("coinc_sh1", 32'(cfg_shadow1), 32'h00008001);
    check_all("coinc");

    // Random frame lengths around the nominal width
    for (int f = 0; f < 6; f++) begin
      rnd = 16'($urandom);
      len = $urandom_range(W + 1, W - 1);
      rsel = 1'($urandom);
      for (int i = 0; i < len; i++) shift_bit(rnd[(i + 5) % W]);
      do_load(rsel);
      check_all("rndlen");
    end

    // Mid-operation reset
    pulse_reset_not();
    shift_word(16'hFFFF, 16);
    do_load(1'b0);
    check("ffff_sh0", 32'(cfg_shadow0), 32'h0000FFFF);
    shift_word(16'($urandom), 8);
    fw_reset_not = 1'b0;
    m_rstn = 1'b0;
    model_clear();
    cyc(10);
    check_all("midrst");
    shift_bit(1'b1);
    shift_bit(1'b1);
    check_all("rst_ign");
    fw_reset_not = 1'b1;
    m_rstn = 1'b1;
    cyc(4);
    check_all("rst_rel");

    // 256 random full loads wrap the load counter
    for (int f = 1; f <= 256; f++) begin
      rnd = 16'($urandom);
      rsel = 1'($urandom);
      shift_word(rnd, 16);
      do_load(rsel);
      check_all("wrap");
      if (f == 255) check("cnt_255", 32'(cfg_load_count), 32'd255);
      if (f == 256) check("cnt_wrap", 32'(cfg_load_count), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
